if_fetch_unit: RTL

Instruction fetch front end that produces the PC / instruction pair consumed by the IF/ID pipeline register. It owns the PC and drives a request/ready handshake to instruction memory with variable latency. It honours the pipeline's freeze and branch-flush signals. It presents a registered output buffer whose contents are consumed on every clock edge where o_Valid=1 and i_Freeze=0.

---
 rtl/if_fetch_unit_if.sv | 23 ++
 rtl/if_fetch_unit.sv | 118 +++++++++++
 2 files changed

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/ready bus between the fetch unit (master) and memory (slave).
interface if_fetch_unit_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  o_Mem_Req;
    logic [DATA_WIDTH-1:0] o_Mem_Addr;
    logic                  i_Mem_Ready;
    logic [DATA_WIDTH-1:0] i_Mem_Rdata;

    modport master (
        output o_Mem_Req,
        output o_Mem_Addr,
        input  i_Mem_Ready,
        input  i_Mem_Rdata
    );

    modport slave (
        input  o_Mem_Req,
        input  o_Mem_Addr,
        output i_Mem_Ready,
        output i_Mem_Rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Fetch front end: owns the PC, issues variable-latency memory requests and
// presents a registered PC/instruction buffer to the IF/ID stage.
module if_fetch_unit #(
    parameter int unsigned          DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_Freeze,
    input  logic                  i_Branch_Taken,
    input  logic [DATA_WIDTH-1:0] i_Branch_Address,
    if_fetch_unit_if.master       mem,
    output logic                  o_Valid,
    output logic [DATA_WIDTH-1:0] o_Pc,
    output logic [DATA_WIDTH-1:0] o_Instruction
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_SKID = 2'd2
    } state_t;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] req_addr_q;
    logic                  discard_q;
    logic                  mem_req_q;
    logic [DATA_WIDTH-1:0] skid_instr_q;
    logic [DATA_WIDTH-1:0] skid_pc_q;
    logic [DATA_WIDTH-1:0] next_addr_c;

    assign next_addr_c    = req_addr_q + DATA_WIDTH'(4);
    assign mem.o_Mem_Req  = mem_req_q;
    assign mem.o_Mem_Addr = req_addr_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            req_addr_q    <= '0;
            discard_q     <= 1'b0;
            mem_req_q     <= 1'b0;
            skid_instr_q  <= '0;
            skid_pc_q     <= '0;
            o_Valid       <= 1'b0;
            o_Pc          <= '0;
            o_Instruction <= '0;
        end else if (i_Branch_Taken) begin
            // Redirect flushes the buffer even under freeze.
            o_Valid       <= 1'b0;
            o_Pc          <= '0;
            o_Instruction <= '0;
            pc_q          <= i_Branch_Address;
            if (state_q == S_REQ) begin
                if (mem.i_Mem_Ready) begin
                    req_addr_q <= i_Branch_Address;
                    discard_q  <= 1'b0;
                end else begin
                    discard_q  <= 1'b1;
                end
            end else begin
                req_addr_q <= i_Branch_Address;
                state_q    <= S_REQ;
                mem_req_q  <= 1'b1;
            end
        end else begin
            // Buffer is consumed unless something below reloads it.
            if (o_Valid && !i_Freeze) begin
                o_Valid       <= 1'b0;
                o_Pc          <= '0;
                o_Instruction <= '0;
            end
            case (state_q)
                S_IDLE: begin
                    req_addr_q <= pc_q;
                    state_q    <= S_REQ;
                    mem_req_q  <= 1'b1;
                end
                S_REQ: begin
                    if (mem.i_Mem_Ready) begin
                        if (discard_q) begin
                            discard_q  <= 1'b0;
                            req_addr_q <= pc_q;
                        end else if (!o_Valid || !i_Freeze) begin
                            o_Valid       <= 1'b1;
                            o_Pc          <= next_addr_c;
                            o_Instruction <= mem.i_Mem_Rdata;
                            pc_q          <= next_addr_c;
                            req_addr_q    <= next_addr_c;
                        end else begin
                            skid_instr_q <= mem.i_Mem_Rdata;
                            skid_pc_q    <= next_addr_c;
                            pc_q         <= next_addr_c;
                            state_q      <= S_SKID;
                            mem_req_q    <= 1'b0;
                        end
                    end
                end
                S_SKID: begin
                    if (!i_Freeze) begin
                        o_Valid       <= 1'b1;
                        o_Pc          <= skid_pc_q;
                        o_Instruction <= skid_instr_q;
                        req_addr_q    <= pc_q;
                        state_q       <= S_REQ;
                        mem_req_q     <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
